alu_operand_regfile: RTL

Execute-stage front end that sits directly upstream of the ALU and drives its a and b operands.
- Holds the 32x32 general-purpose register file: two combinational read ports and one synchronous write port.
- Applies write-through bypass on same-cycle read/write collisions.
- Selects ALU operands: shift amount vs rs on a; extended immediate vs rt on b.
- Also exports raw rt data for store instructions.

---
 rtl/alu_operand_regfile_pkg.sv | 19 +
 rtl/alu_operand_regfile_regfile_2r1w.sv | 47 ++++
 rtl/alu_operand_regfile.sv | 75 +++++++
 3 files changed

// File: rtl/alu_operand_regfile_pkg.sv
// Shared constants and encodings for the execute-stage operand front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_operand_regfile_pkg;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    // Register 0 is architecturally hardwired to zero.
    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    // Immediate extension mode as driven by the control unit's sext line.
    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_mode_e;

endpackage

// File: rtl/alu_operand_regfile_regfile_2r1w.sv
// 2-read/1-write register array with async clear; register 0 always reads zero.
// Latency: reads combinational, writes land on the rising clock edge.
// Backpressure: none; a write is accepted every cycle we is high.
module regfile_2r1w
    import alu_operand_regfile_pkg::*;
#(
    parameter int RF_DW = DW,
    parameter int RF_AW = AW
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             we,
    input  logic [RF_AW-1:0] wn,
    input  logic [RF_DW-1:0] d,
    input  logic [RF_AW-1:0] rna,
    input  logic [RF_AW-1:0] rnb,
    input  logic [RF_AW-1:0] dbg_rn,
    output logic [RF_DW-1:0] qa_raw,
    output logic [RF_DW-1:0] qb_raw,
    output logic [RF_DW-1:0] dbg_q
);

    localparam int RF_NREG = 1 << RF_AW;

    logic [RF_DW-1:0] mem_q [0:RF_NREG-1];
    logic             wr_en;

    // Writes to register 0 are dropped so slot 0 holds its reset value forever.
    assign wr_en = we && (wn != '0);

    // Array storage: async clear wins over any write, including one on the release edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < RF_NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wn] <= d;
        end
    end

    // Raw reads force zero for register 0 so it never depends on storage contents.
    assign qa_raw = (rna    == '0) ? '0 : mem_q[rna];
    assign qb_raw = (rnb    == '0) ? '0 : mem_q[rnb];
    assign dbg_q  = (dbg_rn == '0) ? '0 : mem_q[dbg_rn];

endmodule

// File: rtl/alu_operand_regfile.sv
// Execute-stage operand front end: register file, write-through bypass, ALU a/b select.
// Latency: all outputs combinational from inputs and array state; writes commit on clock edge.
// Backpressure: none; one read pair and one write per cycle.
module alu_operand_regfile
    import alu_operand_regfile_pkg::*;
(
    input  logic          clock,
    input  logic          resetn,
    input  logic          we,
    input  logic [AW-1:0] wn,
    input  logic [DW-1:0] d,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    input  logic          shift,
    input  logic          aluimm,
    input  logic          sext,
    input  logic [15:0]   imm,
    input  logic [4:0]    sa,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [DW-1:0] qb,
    input  logic [AW-1:0] dbg_rn,
    output logic [DW-1:0] dbg_q
);

    logic [DW-1:0] qa_raw;
    logic [DW-1:0] qb_raw;
    logic [DW-1:0] port_a;
    logic [DW-1:0] port_b;
    logic [DW-1:0] imm_ext;
    logic          wr_live;
    logic          byp_a;
    logic          byp_b;
    ext_mode_e     ext_mode;

    regfile_2r1w #(
        .RF_DW (DW),
        .RF_AW (AW)
    ) u_rf (
        .clock  (clock),
        .resetn (resetn),
        .we     (we),
        .wn     (wn),
        .d      (d),
        .rna    (rna),
        .rnb    (rnb),
        .dbg_rn (dbg_rn),
        .qa_raw (qa_raw),
        .qb_raw (qb_raw),
        .dbg_q  (dbg_q)
    );

    // we is evaluated first so an unknown wn cannot leak into the bypass decision when idle.
    assign wr_live = we && (wn != ZERO_REG);
    assign byp_a   = wr_live && (wn == rna);
    assign byp_b   = wr_live && (wn == rnb);
    assign ext_mode = ext_mode_e'(sext);

    // Port reads with write-through: a reader colliding with the writer sees the new data now.
    always_comb begin
        port_a = byp_a ? d : qa_raw;
        port_b = byp_b ? d : qb_raw;
    end

    // Immediate extension and operand selection for the ALU.
    always_comb begin
        imm_ext = {{(DW-16){(ext_mode == EXT_SIGN) & imm[15]}}, imm};
        a       = shift  ? {{(DW-5){1'b0}}, sa} : port_a;
        b       = aluimm ? imm_ext : port_b;
    end

    // Store data is port B regardless of the b-operand select.
    assign qb = port_b;

endmodule
